items_tracker: RTL
==================

# items_tracker

Owns the maze item map (dots and energizers) for the Pac-Man datapath and sits directly upstream of the game controller. On the controller's items-reload request it copies the level's initial item map from an external ROM into an internal map RAM, then returns the items-reload-done handshake. During play it consumes Pac-Man tile updates, removes eaten items, accumulates score, and raises the dot-clear indication the controller uses to end a level. A second read port serves the renderer.

## Interface
- MAP_W, 28, maze width in tiles
- MAP_H, 31, maze height in tiles
- DOT_PTS, 10, score added per dot
- ENG_PTS, 50, score added per energizer
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset; one clock domain
- i_game_state  in  4  controller state; eating is enabled only when equal to GS_PLAY (params.vh)
- i_items_reload  in  1  reload request level from controller
- o_items_reload_done  out  1  reload-complete level
- o_rom_addr  out  10  initial-map ROM address
- i_rom_data  in  2  ROM item code, valid 1 cycle after o_rom_addr
- i_pac_valid  in  1  one-cycle strobe: Pac-Man tile coordinates valid
- i_pac_x  in  5  Pac-Man tile column
- i_pac_y  in  5  Pac-Man tile row
- i_score_clear  in  1  one-cycle strobe: zero the score
- i_rd_x  in  5  renderer query column
- i_rd_y  in  5  renderer query row
- o_rd_item  out  2  item at the queried tile, 1-cycle latency
- o_dot_clear  out  1  all items eaten
- o_power  out  1  one-cycle strobe: energizer eaten
- o_dots_left  out  10  remaining item count
- o_score  out  20  accumulated score

## Operation
- Item codes: 0 empty, 1 dot, 2 energizer, 3 treated as empty (never counted or scored).
- Tile address = y*MAP_W + x (for the default width, (y<<5)-(y<<2)+x), 10 bits. Coordinates with x≥MAP_W or y≥MAP_H are ignored on the eat path; on the renderer port they return 0.
- Map RAM: MAP_W*MAP_H x 2 bits. Port A is renderer read-only. Port B is shared by load and eat; load and eat are mutually exclusive.
- FSM states:
  - S_IDLE: stays until i_items_reload=1, then goes to S_LOAD.
  - S_LOAD: o_rom_addr steps 0..N-1 (N=MAP_W*MAP_H), one address per cycle. Each returned code is written to address-1 on the following cycle. The dot counter is zeroed on entry and incremented for each code 1 or 2. After the final write, goes to S_DONE.
  - S_DONE: o_items_reload_done=1 and the loaded flag is set. When i_items_reload=0, goes to S_IDLE.
- Eat pipeline, active only when loaded and i_game_state==GS_PLAY:
  - Stage 1: on i_pac_valid, read port B at the tile address.
  - Stage 2: if the code is 1 or 2, write 0, decrement o_dots_left, and add DOT_PTS or ENG_PTS to the score. Code 2 also pulses o_power.
  - Forwarding: if stage 2 is clearing address A and stage 1 reads A in the same cycle, stage 1 treats the tile as empty. This prevents a double eat on back-to-back strobes for the same tile.
- o_dot_clear = loaded & (o_dots_left==0). A map with zero items therefore asserts it immediately after load.
- Score saturates at 20'hFFFFF. It is zeroed by i_score_clear. It is not altered by a reload, so the score carries across levels. If i_score_clear coincides with an eat, the clear wins.
- An i_items_reload rise from any state during play aborts the in-flight eat (no write, no score), clears the loaded flag, and enters S_LOAD.

## Timing
- Reset values: o_items_reload_done=0, o_rom_addr=0, o_rd_item=0, o_dot_clear=0, o_power=0, o_dots_left=0, o_score=0, FSM=S_IDLE, loaded=0.
- Load: i_items_reload seen high at edge k → S_LOAD from k+1. o_items_reload_done first high at edge k+N+2. Total sweep is 869 cycles for the default 28x31 map.
- Eat: strobe at edge t → RAM read at t. At t+1 the RAM is updated, and o_dots_left, o_score and o_power all change together. o_dot_clear rises at t+1 on the last item.
- Eat throughput: one strobe per cycle, no back-pressure.
- o_rd_item reflects RAM contents registered one cycle after i_rd_x/i_rd_y. A same-cycle write on port B returns the old value.

## Test plan
- Reset, then pulse i_items_reload with the ROM holding 240 dots and 4 energizers → o_items_reload_done rises 870 cycles later, o_dots_left=244, o_dot_clear=0.
- With GS_PLAY, strobe a dot tile, then an energizer tile → o_score 0→10→60, one o_power pulse, o_dots_left 244→242, and o_rd_item at both tiles reads 0.
- Strobe the same dot tile on 3 consecutive cycles → score +10 once, o_dots_left decrements once.
- Strobes with i_game_state≠GS_PLAY, or with x=28 / y=31 → no change to RAM, score or count.
- Eat all 244 items → o_dot_clear=1 on the cycle after the last eat. Reload → o_dot_clear falls on entry to S_LOAD, and the score is retained.
- Assert i_rst_n=0 mid-load at address 400 → all outputs return to reset values. A fresh reload then completes a full 869-cycle sweep.

Source files
------------

// File: rtl/items_tracker.sv
// Maze item map owner: copies the level map from ROM on reload, removes eaten
// dots/energizers during play, tracks remaining items and the score.
module items_tracker #(
    parameter int unsigned MAP_W   = 28,
    parameter int unsigned MAP_H   = 31,
    parameter int unsigned DOT_PTS = 10,
    parameter int unsigned ENG_PTS = 50,
    parameter logic [3:0]  GS_PLAY = 4'd2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_game_state,
    input  logic       i_items_reload,
    output logic       o_items_reload_done,
    output logic [9:0] o_rom_addr,
    input  logic [1:0] i_rom_data,
    input  logic       i_pac_valid,
    input  logic [4:0] i_pac_x,
    input  logic [4:0] i_pac_y,
    input  logic       i_score_clear,
    input  logic [4:0] i_rd_x,
    input  logic [4:0] i_rd_y,
    output logic [1:0] o_rd_item,
    output logic       o_dot_clear,
    output logic       o_power,
    output logic [9:0] o_dots_left,
    output logic [19:0] o_score
);

    localparam int unsigned N         = MAP_W * MAP_H;
    localparam logic [9:0]  LOAD_END  = 10'(N);
    localparam logic [9:0]  LAST_ADDR = 10'(N - 1);
    localparam logic [19:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [1:0]  map_ram [N];

    logic        reload_q;
    logic        reload_qq;
    logic        reload_rise;
    logic        load_enter;
    logic        load_wr;
    logic [9:0]  load_step;
    logic        loaded;

    logic        pac_in_map;
    logic        rd_in_map;
    logic [9:0]  pac_addr;
    logic [9:0]  rd_addr;
    logic        eat_req;
    logic        fwd_hit;

    logic        s2_valid;
    logic        s2_fwd;
    logic [9:0]  s2_addr;
    logic [1:0]  s2_rd;
    logic [1:0]  s2_code;
    logic        s2_eat;
    logic [19:0] eat_pts;
    logic [20:0] score_sum;

    logic        rd_valid_q;
    logic [1:0]  rd_raw;

    function automatic logic [9:0] tile_addr(input logic [4:0] x, input logic [4:0] y);
        return 10'(y) * 10'(MAP_W) + 10'(x);
    endfunction

    assign pac_in_map = (32'(i_pac_x) < MAP_W) && (32'(i_pac_y) < MAP_H);
    assign rd_in_map  = (32'(i_rd_x) < MAP_W) && (32'(i_rd_y) < MAP_H);
    assign pac_addr   = pac_in_map ? tile_addr(i_pac_x, i_pac_y) : '0;
    assign rd_addr    = rd_in_map ? tile_addr(i_rd_x, i_rd_y) : '0;

    assign reload_rise = reload_q & ~reload_qq;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (reload_q) state_nxt = S_LOAD;
            S_LOAD:  if (load_step == LOAD_END) state_nxt = S_DONE;
            S_DONE:  if (!reload_q) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // A fresh reload request restarts the sweep from any state.
        if (reload_rise) state_nxt = S_LOAD;
    end

    assign load_enter          = (state_nxt == S_LOAD) && ((state != S_LOAD) || reload_rise);
    assign load_wr             = (state == S_LOAD) && (load_step != '0) && !load_enter;
    assign o_rom_addr          = (load_step == LOAD_END) ? LAST_ADDR : load_step;
    assign o_items_reload_done = (state == S_DONE);

    assign eat_req   = i_pac_valid && loaded && (i_game_state == GS_PLAY) && pac_in_map;
    assign s2_code   = s2_fwd ? 2'd0 : s2_rd;
    assign s2_eat    = s2_valid && ((s2_code == 2'd1) || (s2_code == 2'd2)) && !load_enter;
    assign fwd_hit   = s2_eat && (s2_addr == pac_addr);
    assign eat_pts   = (s2_code == 2'd2) ? 20'(ENG_PTS) : 20'(DOT_PTS);
    assign score_sum = {1'b0, o_score} + {1'b0, eat_pts};

    // Port B is shared: load writes and eat clears never overlap in time.
    always_ff @(posedge i_clk) begin
        if (load_wr) begin
            map_ram[load_step - 10'd1] <= i_rom_data;
        end else if (s2_eat) begin
            map_ram[s2_addr] <= '0;
        end
        s2_rd  <= map_ram[pac_addr];
        rd_raw <= map_ram[rd_addr];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            reload_q    <= 1'b0;
            reload_qq   <= 1'b0;
            load_step   <= '0;
            loaded      <= 1'b0;
            o_dots_left <= '0;
            s2_valid    <= 1'b0;
            s2_fwd      <= 1'b0;
            s2_addr     <= '0;
            o_power     <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            reload_q   <= i_items_reload;
            reload_qq  <= reload_q;
            o_power    <= 1'b0;
            rd_valid_q <= rd_in_map;
            if (load_enter) begin
                load_step   <= '0;
                loaded      <= 1'b0;
                o_dots_left <= '0;
                s2_valid    <= 1'b0;
            end else if (state == S_LOAD) begin
                s2_valid <= 1'b0;
                if (load_wr && ((i_rom_data == 2'd1) || (i_rom_data == 2'd2))) begin
                    o_dots_left <= o_dots_left + 10'd1;
                end
                if (load_step == LOAD_END) begin
                    load_step <= '0;
                    loaded    <= 1'b1;
                end else begin
                    load_step <= load_step + 10'd1;
                end
            end else begin
                // Stage 1 sees the tile as empty when stage 2 is clearing it now.
                s2_valid <= eat_req;
                s2_fwd   <= fwd_hit;
                s2_addr  <= pac_addr;
                if (s2_eat) begin
                    o_dots_left <= o_dots_left - 10'd1;
                    o_power     <= (s2_code == 2'd2);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_score <= '0;
        end else if (i_score_clear) begin
            o_score <= '0;
        end else if (s2_eat) begin
            o_score <= score_sum[20] ? SCORE_MAX : score_sum[19:0];
        end
    end

    assign o_rd_item   = rd_valid_q ? rd_raw : 2'd0;
    assign o_dot_clear = loaded && (o_dots_left == '0);

endmodule
